// File: rtl/bsg_wormhole_traffic_gen.sv
// Wormhole bring-up traffic generator: sends numbered packets, checks the looped-back copies.
// Optional watchdog enabled by defining BSG_WH_TRAFFIC_GEN_TIMEOUT_EN.
module bsg_wormhole_traffic_gen #(
    parameter int width_p           = 32,
    parameter int x_cord_width_p    = 2,
    parameter int y_cord_width_p    = 2,
    parameter int len_width_p       = 2,
    parameter int reserved_width_p  = 2,
    parameter int max_len_p         = 2,
    parameter int num_packets_p     = 1000,
    parameter int max_outstanding_p = 8,
    parameter int timeout_p         = 4096
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic                      en_i,
    input  logic [x_cord_width_p-1:0] my_x_cord_i,
    input  logic [x_cord_width_p-1:0] dest_x_cord_i,
    input  logic [y_cord_width_p-1:0] dest_y_cord_i,
    output logic                      valid_o,
    output logic [width_p-1:0]        data_o,
    input  logic                      ready_i,
    input  logic                      valid_i,
    input  logic [width_p-1:0]        data_i,
    output logic                      ready_o,
    output logic [15:0]               sent_count_o,
    output logic [15:0]               recv_count_o,
    output logic                      done_o,
    output logic                      error_o
);
    localparam int X_LO   = reserved_width_p;
    localparam int Y_LO   = X_LO + x_cord_width_p;
    localparam int LEN_LO = Y_LO + y_cord_width_p;
    localparam int NUM_LO = LEN_LO + len_width_p;
    localparam int OUT_W  = $clog2(max_outstanding_p + 1);

    localparam logic [15:0]            NUM_PKTS = 16'(num_packets_p);
    localparam logic [len_width_p-1:0] MAX_LEN  = len_width_p'(max_len_p);
    localparam logic [len_width_p-1:0] LEN_ONE  = len_width_p'(1);
    localparam logic [OUT_W-1:0]       MAX_OUT  = OUT_W'(max_outstanding_p);

    typedef enum logic [1:0] {TX_IDLE, TX_HDR, TX_BODY} tx_state_e;
    typedef enum logic {RX_HDR, RX_BODY} rx_state_e;

    tx_state_e                tx_state_r, tx_state_n;
    rx_state_e                rx_state_r, rx_state_n;
    logic [len_width_p-1:0]   tx_len_r, tx_left_r, rx_len_r, rx_left_r;
    logic [width_p-1:0]       tx_word_r, rx_word_r, data_r;
    logic [15:0]              sent_r, recv_r;
    logic [OUT_W-1:0]         out_r;
    logic                     rdy_r, done_r, err_r, wd_hit;

    logic                     tx_xfer, tx_start, tx_last;
    logic                     rx_flit, rx_last, rx_err;
    logic [width_p-1:0]       tx_hdr;
    logic [x_cord_width_p-1:0] rx_x;
    logic [len_width_p-1:0]   rx_len_f;

    assign valid_o      = (tx_state_r != TX_IDLE);
    assign data_o       = data_r;
    assign ready_o      = rdy_r;
    assign sent_count_o = sent_r;
    assign recv_count_o = recv_r;
    assign done_o       = done_r;
    assign error_o      = err_r;

    assign tx_xfer  = valid_o & ready_i;
    assign tx_start = en_i && (sent_r < NUM_PKTS) && (out_r < MAX_OUT);
    assign tx_last  = tx_xfer && ((tx_state_r == TX_HDR && tx_len_r == '0) ||
                                  (tx_state_r == TX_BODY && tx_left_r == LEN_ONE));
    assign tx_hdr   = (width_p'(sent_r) << NUM_LO) | (width_p'(tx_len_r) << LEN_LO)
                    | (width_p'(dest_y_cord_i) << Y_LO) | (width_p'(dest_x_cord_i) << X_LO);

    always_comb begin
        tx_state_n = tx_state_r;
        case (tx_state_r)
            TX_IDLE: if (tx_start) tx_state_n = TX_HDR;
            TX_HDR:  if (tx_xfer) tx_state_n = (tx_len_r == '0) ? TX_IDLE : TX_BODY;
            TX_BODY: if (tx_last) tx_state_n = TX_IDLE;
            default: tx_state_n = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            tx_state_r <= TX_IDLE;
            data_r     <= '0;
            tx_len_r   <= '0;
            tx_left_r  <= '0;
            tx_word_r  <= '0;
            sent_r     <= '0;
        end else begin
            tx_state_r <= tx_state_n;
            // data_r only moves on a load or a transfer, so it is held while stalled
            if (tx_state_r == TX_IDLE && tx_start)
                data_r <= tx_hdr;
            else if (tx_xfer)
                data_r <= (tx_state_r == TX_HDR) ? tx_word_r : tx_word_r + 1'b1;
            if (tx_xfer && tx_state_r == TX_HDR)
                tx_left_r <= tx_len_r;
            else if (tx_xfer && tx_state_r == TX_BODY)
                tx_left_r <= tx_left_r - 1'b1;
            if (tx_xfer && tx_state_r == TX_BODY)
                tx_word_r <= tx_word_r + 1'b1;
            if (tx_last) begin
                sent_r   <= sent_r + 1'b1;
                tx_len_r <= (tx_len_r == MAX_LEN) ? '0 : tx_len_r + 1'b1;
            end
        end
    end

    assign rx_flit  = valid_i & rdy_r;
    assign rx_x     = data_i[X_LO +: x_cord_width_p];
    assign rx_len_f = data_i[LEN_LO +: len_width_p];
    assign rx_last  = rx_flit && ((rx_state_r == RX_HDR && rx_len_f == '0) ||
                                  (rx_state_r == RX_BODY && rx_left_r == LEN_ONE));
    // A packet still being transmitted counts as in flight, so tight loopback is legal.
    assign rx_err   = rx_flit && ((out_r == '0 && tx_state_r == TX_IDLE) ||
                      (rx_state_r == RX_HDR && (rx_x != my_x_cord_i || rx_len_f != rx_len_r)) ||
                      (rx_state_r == RX_BODY && data_i != rx_word_r));

    always_comb begin
        rx_state_n = rx_state_r;
        case (rx_state_r)
            RX_HDR:  if (rx_flit && rx_len_f != '0) rx_state_n = RX_BODY;
            RX_BODY: if (rx_last) rx_state_n = RX_HDR;
            default: rx_state_n = RX_HDR;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            rx_state_r <= RX_HDR;
            rx_len_r   <= '0;
            rx_left_r  <= '0;
            rx_word_r  <= '0;
            recv_r     <= '0;
            rdy_r      <= 1'b0;
            done_r     <= 1'b0;
            err_r      <= 1'b0;
        end else begin
            rx_state_r <= rx_state_n;
            rdy_r      <= 1'b1;
            done_r     <= (recv_r == NUM_PKTS);
            err_r      <= err_r | rx_err | wd_hit;
            if (rx_flit && rx_state_r == RX_HDR)
                rx_left_r <= rx_len_f;
            else if (rx_flit && rx_state_r == RX_BODY)
                rx_left_r <= rx_left_r - 1'b1;
            if (rx_flit && rx_state_r == RX_BODY)
                rx_word_r <= rx_word_r + 1'b1;
            if (rx_last) begin
                if (recv_r < NUM_PKTS) recv_r <= recv_r + 1'b1;
                rx_len_r <= (rx_len_r == MAX_LEN) ? '0 : rx_len_r + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i)
            out_r <= '0;
        else if (tx_last && !rx_last)
            out_r <= out_r + 1'b1;
        else if (rx_last && !tx_last && out_r != '0)
            out_r <= out_r - 1'b1;
    end

`ifdef BSG_WH_TRAFFIC_GEN_TIMEOUT_EN
    localparam int WD_W = $clog2(timeout_p + 1);
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(timeout_p);
    logic [WD_W-1:0] wd_r;
    logic            wd_clr;

    assign wd_clr = rx_flit || (out_r == '0);
    assign wd_hit = !wd_clr && (wd_r == WD_MAX - 1'b1);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i)
            wd_r <= '0;
        else if (wd_clr)
            wd_r <= '0;
        else if (wd_r != WD_MAX)
            wd_r <= wd_r + 1'b1;
    end
`else
    assign wd_hit = 1'b0;
`endif

endmodule

// File: tb/tb_bsg_wormhole_traffic_gen.sv
// Bench for bsg_wormhole_traffic_gen: loopback scenarios against a flit-list model plus directed error/reset cases.
module tb_bsg_wormhole_traffic_gen;
    localparam int N = 10;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0, ready_i = 1'b0, lb = 1'b0, inj_v = 1'b0;
    logic [31:0] inj_d = '0;
    logic [1:0]  my_x = 2'd3, dx = 2'd3, dy = 2'd1;
    logic        valid_o, valid_i, ready_o, done, err;
    logic [31:0] data_o, data_i;
    logic [15:0] sent, recv;

    int nvec = 0, nerr = 0;

    assign valid_i = lb ? (valid_o & ready_i) : inj_v;
    assign data_i  = lb ? data_o : inj_d;

    always #5 clk = ~clk;

    bsg_wormhole_traffic_gen #(.num_packets_p(N), .max_outstanding_p(8)) dut (
        .clk_i(clk), .reset_i(rst), .en_i(en),
        .my_x_cord_i(my_x), .dest_x_cord_i(dx), .dest_y_cord_i(dy),
        .valid_o(valid_o), .data_o(data_o), .ready_i(ready_i),
        .valid_i(valid_i), .data_i(data_i), .ready_o(ready_o),
        .sent_count_o(sent), .recv_count_o(recv), .done_o(done), .error_o(err)
    );

    typedef struct {
        bit lb;
        int rmode;
        int budget;
        int sent;
        int recv;
        bit done;
        bit err;
        int left;
    } scen_t;

    scen_t tbl[4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] hdr(input int k, input int len, input int x, input int y);
        return (32'(k) << 8) | (32'(len) << 6) | (32'(y) << 4) | (32'(x) << 2);
    endfunction

    task automatic do_reset();
        rst = 1'b1; en = 1'b0; lb = 1'b0; inj_v = 1'b0; ready_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic rx_flit(input logic [31:0] d);
        inj_v = 1'b1; inj_d = d;
        @(negedge clk);
        inj_v = 1'b0;
    endtask

    task automatic wait_sent(input int n);
        int c = 0;
        while (sent < 16'(n) && c < 300) begin @(negedge clk); c++; end
        chk("wait_sent", 32'(sent), 32'(n));
    endtask

    task automatic run_scen(input scen_t s);
        logic [31:0] q[$];
        int  wrd = 0, cyc = 0;
        bit  pv = 0, pr = 0;
        for (int k = 0; k < N; k++) begin
            q.push_back(hdr(k, k % 3, 3, 1));
            for (int j = 0; j < k % 3; j++) q.push_back(32'(wrd++));
        end
        do_reset();
        lb = s.lb; en = 1'b1;
        while (cyc < s.budget && !(s.done && done)) begin
            if (pv && !pr) chk("vhold", 32'(valid_o), 32'd1);
            case (s.rmode)
                0:       ready_i = 1'b1;
                1:       ready_i = (cyc % 3 == 0);
                default: ready_i = 1'($urandom_range(0, 1));
            endcase
            if (valid_o) begin
                if (q.size() == 0) chk("extra_flit", 32'(valid_o), 32'd0);
                else begin
                    chk("flit", data_o, q[0]);
                    if (ready_i) void'(q.pop_front());
                end
            end
            pv = valid_o; pr = ready_i; cyc++;
            @(negedge clk);
        end
        chk("sent", 32'(sent), 32'(s.sent));
        chk("recv", 32'(recv), 32'(s.recv));
        chk("done", 32'(done), 32'(s.done));
        chk("err", 32'(err), 32'(s.err));
        chk("left", 32'(q.size()), 32'(s.left));
        chk("valid_idle", 32'(valid_o), 32'd0);
    endtask

    initial begin
        logic [31:0] got[$];
        int wrd, c;

        tbl[0] = '{1, 0, 400, 10, 10, 1, 0, 0};
        tbl[1] = '{1, 1, 400, 10, 10, 1, 0, 0};
        tbl[2] = '{1, 2, 800, 10, 10, 1, 0, 0};
        tbl[3] = '{0, 0, 200,  8,  0, 0, 0, 4};

        // reset values while reset is held
        @(negedge clk);
        chk("rst_valid", 32'(valid_o), 0);
        chk("rst_data",  data_o, 0);
        chk("rst_ready", 32'(ready_o), 0);
        chk("rst_sent",  32'(sent), 0);
        chk("rst_recv",  32'(recv), 0);
        chk("rst_done",  32'(done), 0);
        chk("rst_err",   32'(err), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("ready_up", 32'(ready_o), 1);

        for (int i = 0; i < 4; i++) run_scen(tbl[i]);

        // wrong body word: packets 0..4 consume words 0..3, packet 5 expects 4
        do_reset();
        ready_i = 1'b1; en = 1'b1;
        wait_sent(6);
        en = 1'b0;
        repeat (3) @(negedge clk);
        wrd = 0;
        for (int k = 0; k < 5; k++) begin
            rx_flit(hdr(k, k % 3, 3, 1));
            for (int j = 0; j < k % 3; j++) rx_flit(32'(wrd++));
        end
        chk("err_clean", 32'(err), 0);
        chk("recv5", 32'(recv), 5);
        rx_flit(hdr(5, 2, 3, 1));
        chk("err_hdr5", 32'(err), 0);
        rx_flit(32'h5);
        chk("bad_word", 32'(err), 1);
        rx_flit(32'h5);
        repeat (3) @(negedge clk);
        chk("sticky", 32'(err), 1);
        chk("sent_held", 32'(sent), 6);

        // wrong x coordinate in returned header
        do_reset();
        ready_i = 1'b1; en = 1'b1;
        wait_sent(1);
        chk("err_pre_x", 32'(err), 0);
        rx_flit(hdr(0, 0, 2, 1));
        chk("bad_x", 32'(err), 1);

        // reset in the middle of packet 2's body
        do_reset();
        ready_i = 1'b1; en = 1'b1;
        c = 0;
        while (!(valid_o && sent == 16'd2 && data_o == 32'd1) && c < 100) begin
            @(negedge clk); c++;
        end
        chk("mid_body", data_o, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("rst_mid_valid", 32'(valid_o), 0);
        chk("rst_mid_sent",  32'(sent), 0);
        chk("rst_mid_data",  data_o, 0);
        @(negedge clk);
        rst = 1'b0;
        c = 0;
        while (got.size() < 3 && c < 50) begin
            if (valid_o && ready_i) got.push_back(data_o);
            @(negedge clk); c++;
        end
        chk("restart_n", 32'(got.size()), 3);
        if (got.size() == 3) begin
            chk("restart_h0", got[0], hdr(0, 0, 3, 1));
            chk("restart_h1", got[1], hdr(1, 1, 3, 1));
            chk("restart_w0", got[2], 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
